// File: rtl/mips_pkg.sv
// mips_pkg: shared MIPS opcodes, data-memory access sizes and default depth.
package mips_pkg;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam int unsigned DM_DEPTH_WORDS_DEFAULT = 3072;
    typedef enum logic [1:0] {SZ_WORD, SZ_HALF, SZ_BYTE} dm_size_e;
endpackage

// File: rtl/dm_lane_unit.sv
// dm_lane_unit: byte-enable mask, store merge and load extension for one word.
module dm_lane_unit
    import mips_pkg::*;
(
    input  dm_size_e    size_i,
    input  logic [1:0]  lane_i,
    input  logic        sign_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] old_i,
    output logic [3:0]  be_o,
    output logic [31:0] merged_o,
    output logic [31:0] rdata_o
);
    logic [31:0] wrep;
    logic [15:0] half;
    logic [7:0]  byt;
    always_comb begin
        be_o = size_i == SZ_WORD ? 4'hF : size_i == SZ_HALF ? (lane_i[1] ? 4'hC : 4'h3) : 4'b0001 << lane_i;
        // replicate store data so every enabled lane sees its own bytes
        wrep = size_i == SZ_WORD ? wdata_i : size_i == SZ_HALF ? {2{wdata_i[15:0]}} : {4{wdata_i[7:0]}};
        merged_o = old_i;
        for (int k = 0; k < 4; k++) merged_o[8*k +: 8] = be_o[k] ? wrep[8*k +: 8] : old_i[8*k +: 8];
        half = lane_i[1] ? old_i[31:16] : old_i[15:0];
        byt = old_i[8*lane_i +: 8];
        rdata_o = size_i == SZ_WORD ? old_i :
                  size_i == SZ_HALF ? {{16{sign_i & half[15]}}, half} : {{24{sign_i & byt[7]}}, byt};
    end
endmodule

// File: rtl/mem_stage_dm.sv
// mem_stage_dm: MIPS M-stage data memory; sync-write word array, combinational extended loads.
// Define DM_WRITE_LOG_EN to print every committed store.
module mem_stage_dm
    import mips_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = DM_DEPTH_WORDS_DEFAULT,
    parameter int unsigned ADDR_LSB    = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] M_PC,
    input  logic [31:0] M_Instruction,
    input  logic [31:0] M_AluC,
    input  logic [31:0] M_WriteData,
    output logic [31:0] M_DMrd
);
    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] mem_d, old_word, rdata;
    logic [5:0]  op;
    logic [11:0] idx;
    logic [3:0]  be;
    logic        is_load, is_store, sign, in_range;
    dm_size_e    size;
    logic        unused_ok;
    always_comb begin
        op = M_Instruction[31:26];
        is_load = op inside {OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU};
        is_store = op inside {OP_SW, OP_SH, OP_SB};
        size = op inside {OP_LW, OP_SW} ? SZ_WORD : op inside {OP_LH, OP_LHU, OP_SH} ? SZ_HALF : SZ_BYTE;
        sign = op inside {OP_LH, OP_LB};
        idx = M_AluC[ADDR_LSB +: 12];
        in_range = M_AluC[31:ADDR_LSB+12] == '0 && 32'(idx) < DEPTH_WORDS;
        old_word = in_range ? mem_q[idx] : '0;
        M_DMrd = is_load && in_range ? rdata : '0;
    end
    dm_lane_unit u_lane (
        .size_i   (size),
        .lane_i   (M_AluC[1:0]),
        .sign_i   (sign),
        .wdata_i  (M_WriteData),
        .old_i    (old_word),
        .be_o     (be),
        .merged_o (mem_d),
        .rdata_o  (rdata)
    );
    // reset clear wins over a concurrent store
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < int'(DEPTH_WORDS); i++) mem_q[i] <= '0;
        end else if (is_store && in_range) begin
            mem_q[idx] <= mem_d;
`ifdef DM_WRITE_LOG_EN
            $display("@%h: *%h <= %h", M_PC, {M_AluC[31:2], 2'b00}, mem_d);
`else
`endif
        end
    end
    assign unused_ok = ^{M_PC, M_Instruction[25:0], be};
endmodule

// File: tb/tb_mem_stage_dm.sv
// tb_mem_stage_dm: directed stimulus, byte-level reference model checked every cycle plus literal pins.
module tb_mem_stage_dm;
    localparam logic [5:0] LW = 6'b100011, LH = 6'b100001, LHU = 6'b100101, LB = 6'b100000, LBU = 6'b100100;
    localparam logic [5:0] SW = 6'b101011, SH = 6'b101001, SB = 6'b101000, NOP = 6'b000000;
    localparam int NBYTES = 4 * 3072;
    logic        Clk, Reset;
    logic [31:0] M_PC, M_Instruction, M_AluC, M_WriteData, M_DMrd;
    logic [7:0]  mb [NBYTES];
    int          errors = 0, checks = 0;
    logic        started = 0;
    mem_stage_dm dut (
        .Clk(Clk), .Reset(Reset), .M_PC(M_PC), .M_Instruction(M_Instruction),
        .M_AluC(M_AluC), .M_WriteData(M_WriteData), .M_DMrd(M_DMrd)
    );
    initial begin
        Clk = 0;
        forever #5 Clk = ~Clk;
    end
    function automatic logic [31:0] mload(input logic [5:0] op, input logic [31:0] a);
        int b;
        logic [15:0] h;
        if (a >= NBYTES) return 0;
        b = int'(a);
        h = {mb[(b & ~1) + 1], mb[b & ~1]};
        case (op)
            LW:  return {mb[(b & ~3) + 3], mb[(b & ~3) + 2], mb[(b & ~3) + 1], mb[b & ~3]};
            LH:  return {{16{h[15]}}, h};
            LHU: return {16'h0, h};
            LB:  return {{24{mb[b][7]}}, mb[b]};
            LBU: return {24'h0, mb[b]};
            default: return 0;
        endcase
    endfunction
    initial forever begin
        @(posedge Clk);
        if (Reset) begin
            for (int i = 0; i < NBYTES; i++) mb[i] = 8'h0;
        end else if (M_AluC < NBYTES) begin
            case (M_Instruction[31:26])
                SW: for (int k = 0; k < 4; k++) mb[int'(M_AluC & ~32'h3) + k] = M_WriteData[8*k +: 8];
                SH: begin
                    mb[int'(M_AluC & ~32'h1)] = M_WriteData[7:0];
                    mb[int'(M_AluC & ~32'h1) + 1] = M_WriteData[15:8];
                end
                SB: mb[int'(M_AluC)] = M_WriteData[7:0];
                default: ;
            endcase
        end
    end
    always @(negedge Clk) begin
        logic [31:0] exp;
        if (started) begin
            exp = mload(M_Instruction[31:26], M_AluC);
            checks++;
            if (M_DMrd !== exp) begin
                errors++;
                $display("FAIL model op=%b addr=%h: got %h want %h", M_Instruction[31:26], M_AluC, M_DMrd, exp);
            end
        end
    end
    task automatic drive(input logic [5:0] op, input logic [31:0] a, input logic [31:0] d, input logic rst);
        @(posedge Clk);
        #1;
        Reset = rst;
        M_Instruction = {op, 26'h0};
        M_AluC = a;
        M_WriteData = d;
        M_PC = M_PC + 4;
    endtask
    task automatic lit(input string name, input logic [31:0] want);
        #2;
        checks++;
        if (M_DMrd !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, M_DMrd, want);
        end
    endtask
    initial begin
        Reset = 1;
        M_PC = 32'h0040_0000;
        M_Instruction = 0;
        M_AluC = 0;
        M_WriteData = 0;
        for (int i = 0; i < NBYTES; i++) mb[i] = 8'h0;
        drive(NOP, 0, 0, 1);
        drive(NOP, 0, 0, 1);
        drive(NOP, 0, 0, 0);
        started = 1;
        drive(LW, 32'h0, 0, 0);          lit("rst_lw_0", 32'h0);
        drive(LW, 32'h10, 0, 0);         lit("rst_lw_10", 32'h0);
        drive(LW, 32'h2FFC, 0, 0);       lit("rst_lw_2ffc", 32'h0);
        drive(SW, 32'h100, 32'h12345678, 0); lit("sw_dmrd_zero", 32'h0);
        drive(LW, 32'h100, 0, 0);        lit("lw_after_sw", 32'h12345678);
        drive(SB, 32'h101, 32'hFFFFFFAB, 0);
        drive(LW, 32'h100, 0, 0);        lit("lw_after_sb", 32'h1234AB78);
        drive(LB, 32'h101, 0, 0);        lit("lb_101", 32'hFFFFFFAB);
        drive(LBU, 32'h101, 0, 0);       lit("lbu_101", 32'h000000AB);
        drive(LH, 32'h102, 0, 0);        lit("lh_102", 32'h00001234);
        drive(SH, 32'h102, 32'hDEAD8001, 0);
        drive(LH, 32'h102, 0, 0);        lit("lh_after_sh", 32'hFFFF8001);
        drive(LHU, 32'h102, 0, 0);       lit("lhu_after_sh", 32'h00008001);
        drive(LW, 32'h100, 0, 0);        lit("lw_after_sh", 32'h8001AB78);
        drive(SW, 32'h3000, 32'hCAFEBABE, 0);
        drive(LW, 32'h3000, 0, 0);       lit("lw_oor_3000", 32'h0);
        drive(SW, 32'h4100, 32'h5A5A5A5A, 0);
        drive(LW, 32'h100, 0, 0);        lit("lw_100_no_alias", 32'h8001AB78);
        drive(LW, 32'h4100, 0, 0);       lit("lw_oor_4100", 32'h0);
        drive(SW, 32'h2FFC, 32'h11223344, 0);
        drive(LW, 32'h2FFC, 0, 0);       lit("lw_last_word", 32'h11223344);
        drive(LB, 32'h2FFF, 0, 0);       lit("lb_last_byte", 32'h00000011);
        drive(LH, 32'h2FFE, 0, 0);       lit("lh_last_half", 32'h00001122);
        drive(NOP, 32'h100, 32'hFFFFFFFF, 0); lit("nop_zero", 32'h0);
        drive(LW, 32'h100, 0, 0);        lit("nop_no_write", 32'h8001AB78);
        drive(SW, 32'h100, 32'hFFFFFFFF, 1);
        drive(LW, 32'h100, 0, 0);        lit("reset_beats_sw", 32'h0);
        drive(LW, 32'h2FFC, 0, 0);       lit("reset_clears_all", 32'h0);
        drive(SB, 32'h103, 32'h00000080, 0);
        drive(LB, 32'h103, 0, 0);        lit("lb_103", 32'hFFFFFF80);
        drive(LHU, 32'h102, 0, 0);       lit("lhu_102", 32'h00008000);
        drive(LBU, 32'h102, 0, 0);       lit("lbu_102", 32'h00000000);
        drive(NOP, 0, 0, 0);
        drive(NOP, 0, 0, 0);
        started = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
